replay_ctrl: RTL and testbench
==============================

# replay_ctrl

Synthesizable sequencer for the replay harness. Holds the DUT in reset for a configured number of cycles, then advances the replay engine one tick per request/acknowledge handshake and counts completed cycles. Opens and closes a waveform-dump window at configured cycle numbers and terminates the run on an engine exit request or a cycle limit. Sits between the replay testbench top and the tick engine, replacing free-running cycle and dump bookkeeping with one deterministic FSM.

## Interface
- CYCLE_W, 64, width of cycle counter and cycle-number config fields
- RST_W, 16, width of reset-length field

- clock  in  1  single clock
- reset  in  1  synchronous, active-high; returns block to IDLE
- cfg_valid  in  1  run configuration offered
- cfg_ready  out  1  high only in IDLE
- cfg_reset_len  in  RST_W  DUT reset hold length in cycles; 0 treated as 1
- cfg_dump_start  in  CYCLE_W  cycle number at which dump opens
- cfg_dump_end  in  CYCLE_W  cycle number at which dump closes; 0 = never
- cfg_max_cycles  in  CYCLE_W  run limit; 0 = unlimited
- tick_req  out  1  request one engine tick
- tick_ack  in  1  engine completed tick
- tick_exit  in  1  engine exit flag, sampled with tick_ack
- dut_reset  out  1  DUT reset
- cycles  out  CYCLE_W  completed ticks since reset release
- dump_on, dump_off  out  1  single-cycle pulses
- dump_active  out  1  dump window open
- finish  out  1  single-cycle pulse at end of run
- done  out  1  sticky until reset
- exit_cause  out  2  0 none, 1 engine exit, 2 cycle limit

## Operation
- States: IDLE, RST_HOLD, RUN, CLOSE, FIN, DONE.
- IDLE: cfg_ready=1, dut_reset=1. On cfg_valid the configuration is latched, the hold counter is loaded with max(cfg_reset_len,1), and the FSM goes to RST_HOLD.
- RST_HOLD: dut_reset=1. The counter decrements each cycle. When it reaches 1, the FSM goes to RUN and dut_reset drops on entry.
- RUN: tick_req=1. Each tick_ack is one handshake.
  - ack with tick_exit=1: cycles unchanged, exit_cause=1, go to CLOSE.
  - ack with tick_exit=0: cycles←cycles+1. If the new value equals a nonzero cfg_max_cycles, exit_cause=2 and go to CLOSE.
- Dump window, evaluated on the new cycles value at a non-exit ack:
  - When it equals cfg_dump_start and the window is not yet open: pulse dump_on, set dump_active.
  - When it equals a nonzero cfg_dump_end, cfg_dump_end > cfg_dump_start, and the window is open: pulse dump_off, clear dump_active.
  - cfg_dump_start=0: dump_on pulses on the first RUN cycle.
  - The window opens at most once per run.
- CLOSE: if dump_active, pulse dump_off and clear it. Go to FIN.
- FIN: pulse finish, go to DONE.
- DONE: done=1, tick_req=0, dut_reset=1. Leaves only on reset.
- Boundary conditions:
  - Exit ack on the same cycle as a dump_start match: exit wins, no dump_on.
  - Limit hit on the same cycle as a dump_start match: dump_on pulses, then dump_off follows in CLOSE.
  - cycles saturates at all-ones and does not wrap.
  - cfg_dump_end ≤ cfg_dump_start (nonzero end): window never closes early; it closes in CLOSE.
  - Reset mid-run: all state cleared immediately, no dump_off or finish pulse.

## Timing
- All outputs are registered.
- Reset values: cfg_ready=1, dut_reset=1, tick_req=0, cycles=0, dump_on=0, dump_off=0, dump_active=0, finish=0, done=0, exit_cause=0.
- cfg accept to dut_reset low: max(cfg_reset_len,1)+1 cycles.
- cycles updates one cycle after the accepted ack.
- tick_req stays high across back-to-back acks; one ack is accepted per cycle.
- Exit or limit ack to finish pulse: 2 cycles (CLOSE, FIN). done rises the following cycle.

## Structure
- replay_ctrl_pkg: state enum, exit-cause enum (EXIT_NONE, EXIT_ENGINE, EXIT_LIMIT), CYCLE_W/RST_W defaults.
- Sub-module replay_dump_window: start/end compare, open-once flag, dump_on/dump_off pulse generation. Inputs are the cycle-advance strobe and the new count.

## Test plan
- reset_len=3, start=0, end=0, max=0; engine acks 10 times, exit on the 11th -> dut_reset high 4 cycles after accept; dump_on in first RUN cycle; cycles=10; dump_off, then finish 1 cycle later; exit_cause=1.
- reset_len=0, start=5, end=8, max=20, continuous acks -> dump_on when cycles becomes 5, dump_off when cycles becomes 8, finish when cycles=20, exit_cause=2.
- start=4, engine exit on the ack that would make cycles 4 -> no dump_on, cycles=3, no dump_off, finish pulses.
- start=6, max=6 -> dump_on and limit on the same ack; dump_off in CLOSE; finish next cycle.
- Assert reset during RUN with dump_active=1 -> next cycle all outputs at reset values, no dump_off or finish pulse; a new cfg is accepted.
- Acks gapped by random idle cycles, max=50 -> cycles advances only on acks; finish at cycles=50; done sticky until reset.

Source files
------------

// File: rtl/replay_ctrl_pkg.sv
// Shared types and defaults for the replay sequencer.
// Contents: FSM state enum, exit-cause enum, default widths for the cycle counter
// and the DUT reset-length field.
package replay_ctrl_pkg;

    localparam int unsigned CYCLE_W_DFLT = 64;
    localparam int unsigned RST_W_DFLT   = 16;

    typedef enum logic [2:0] {
        StIdle,
        StRstHold,
        StRun,
        StClose,
        StFin,
        StDone
    } state_e;

    typedef enum logic [1:0] {
        EXIT_NONE   = 2'd0,
        EXIT_ENGINE = 2'd1,
        EXIT_LIMIT  = 2'd2
    } exit_cause_e;

endpackage

// File: rtl/replay_dump_window.sv
// Waveform-dump window tracker for one replay run.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   clr_i               new run accepted: forget any previous window
//   start_i             run is entering its first RUN cycle (count is 0)
//   adv_i, cnt_i        a cycle completed; cnt_i is the new cycle count
//   dump_start_i/end_i  configured open/close cycle numbers (end 0 = never)
//   close_i             run is closing: shut an open window
//   dump_on_o/off_o     registered single-cycle pulses
//   dump_active_o       window currently open
module replay_dump_window
    import replay_ctrl_pkg::*;
#(
    parameter int unsigned CYCLE_W = CYCLE_W_DFLT
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clr_i,
    input  logic               start_i,
    input  logic               adv_i,
    input  logic [CYCLE_W-1:0] cnt_i,
    input  logic [CYCLE_W-1:0] dump_start_i,
    input  logic [CYCLE_W-1:0] dump_end_i,
    input  logic               close_i,
    output logic               dump_on_o,
    output logic               dump_off_o,
    output logic               dump_active_o
);

    logic on_d, on_q, off_d, off_q;
    logic active_d, active_q, opened_d, opened_q;
    logic open_hit, end_hit;

    always_comb begin
        on_d     = 1'b0;
        off_d    = 1'b0;
        active_d = active_q;
        opened_d = opened_q;
        // The window may open only once per run; a start of 0 opens on RUN entry.
        open_hit = !opened_q &&
                   ((start_i && (dump_start_i == '0)) || (adv_i && (cnt_i == dump_start_i)));
        // An end at or below the start never closes the window early.
        end_hit  = adv_i && (dump_end_i != '0) && (dump_end_i > dump_start_i) &&
                   (cnt_i == dump_end_i);
        if (clr_i) begin
            active_d = 1'b0;
            opened_d = 1'b0;
        end else if (open_hit) begin
            // Opening wins over a close on the same edge; the close lands next cycle.
            on_d     = 1'b1;
            active_d = 1'b1;
            opened_d = 1'b1;
        end else if (active_q && (end_hit || close_i)) begin
            off_d    = 1'b1;
            active_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            on_q     <= 1'b0;
            off_q    <= 1'b0;
            active_q <= 1'b0;
            opened_q <= 1'b0;
        end else begin
            on_q     <= on_d;
            off_q    <= off_d;
            active_q <= active_d;
            opened_q <= opened_d;
        end
    end

    assign dump_on_o     = on_q;
    assign dump_off_o    = off_q;
    assign dump_active_o = active_q;

endmodule

// File: rtl/replay_ctrl.sv
// Replay sequencer: holds the DUT in reset, then runs the tick engine one
// request/acknowledge handshake at a time, counting completed cycles, driving the
// dump window and ending the run on an engine exit or the cycle limit.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   cfg_*                   run configuration, accepted while cfg_ready_o is high
//   tick_req_o/ack_i/exit_i engine handshake; exit sampled with ack
//   dut_reset_o             DUT reset
//   cycles_o                completed ticks since reset release (saturating)
//   dump_on_o/off_o         dump window pulses, dump_active_o window open
//   finish_o                end-of-run pulse, done_o sticky until reset
//   exit_cause_o            0 none, 1 engine exit, 2 cycle limit
module replay_ctrl
    import replay_ctrl_pkg::*;
#(
    parameter int unsigned CYCLE_W = CYCLE_W_DFLT,
    parameter int unsigned RST_W   = RST_W_DFLT
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cfg_valid_i,
    output logic               cfg_ready_o,
    input  logic [RST_W-1:0]   cfg_reset_len_i,
    input  logic [CYCLE_W-1:0] cfg_dump_start_i,
    input  logic [CYCLE_W-1:0] cfg_dump_end_i,
    input  logic [CYCLE_W-1:0] cfg_max_cycles_i,
    output logic               tick_req_o,
    input  logic               tick_ack_i,
    input  logic               tick_exit_i,
    output logic               dut_reset_o,
    output logic [CYCLE_W-1:0] cycles_o,
    output logic               dump_on_o,
    output logic               dump_off_o,
    output logic               dump_active_o,
    output logic               finish_o,
    output logic               done_o,
    output logic [1:0]         exit_cause_o
);

    localparam logic [RST_W-1:0]   HoldOne = RST_W'(1);
    localparam logic [CYCLE_W-1:0] CycOne  = CYCLE_W'(1);

    state_e             state_d, state_q;
    logic [RST_W-1:0]   hold_d, hold_q;
    logic [CYCLE_W-1:0] cycles_d, cycles_q, cycles_inc;
    exit_cause_e        cause_d, cause_q;
    logic [CYCLE_W-1:0] start_d, start_q, end_d, end_q, max_d, max_q;
    logic               cfg_ready_q, dut_reset_q, tick_req_q, finish_q, done_q;
    logic               win_clr, win_start, win_adv, win_close;

    // Saturate instead of wrapping so a runaway run never aliases to a small count.
    assign cycles_inc = (cycles_q == '1) ? cycles_q : cycles_q + CycOne;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        cycles_d  = cycles_q;
        cause_d   = cause_q;
        start_d   = start_q;
        end_d     = end_q;
        max_d     = max_q;
        win_clr   = 1'b0;
        win_start = 1'b0;
        win_adv   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cfg_valid_i) begin
                    start_d  = cfg_dump_start_i;
                    end_d    = cfg_dump_end_i;
                    max_d    = cfg_max_cycles_i;
                    hold_d   = (cfg_reset_len_i == '0) ? HoldOne : cfg_reset_len_i;
                    cycles_d = '0;
                    cause_d  = EXIT_NONE;
                    win_clr  = 1'b1;
                    state_d  = StRstHold;
                end
            end
            StRstHold: begin
                if (hold_q <= HoldOne) begin
                    win_start = 1'b1;
                    state_d   = StRun;
                end else begin
                    hold_d = hold_q - HoldOne;
                end
            end
            StRun: begin
                if (tick_ack_i) begin
                    if (tick_exit_i) begin
                        // Exit takes precedence: the count and dump window stay put.
                        cause_d = EXIT_ENGINE;
                        state_d = StClose;
                    end else begin
                        cycles_d = cycles_inc;
                        win_adv  = 1'b1;
                        if ((max_q != '0) && (cycles_inc == max_q)) begin
                            cause_d = EXIT_LIMIT;
                            state_d = StClose;
                        end
                    end
                end
            end
            StClose: state_d = StFin;
            StFin:   state_d = StDone;
            StDone:  state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    // Close strobe covers both the edge into CLOSE and the one leaving it, so a
    // window opened by the final ack still gets its dump_off one cycle later.
    assign win_close = (state_d == StClose) || (state_q == StClose);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            hold_q      <= '0;
            cycles_q    <= '0;
            cause_q     <= EXIT_NONE;
            start_q     <= '0;
            end_q       <= '0;
            max_q       <= '0;
            cfg_ready_q <= 1'b1;
            dut_reset_q <= 1'b1;
            tick_req_q  <= 1'b0;
            finish_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            cycles_q    <= cycles_d;
            cause_q     <= cause_d;
            start_q     <= start_d;
            end_q       <= end_d;
            max_q       <= max_d;
            // Outputs are registered from the next state so each is valid in its state.
            cfg_ready_q <= (state_d == StIdle);
            dut_reset_q <= (state_d == StIdle) || (state_d == StRstHold) ||
                           (state_d == StDone);
            tick_req_q  <= (state_d == StRun);
            finish_q    <= (state_d == StFin);
            done_q      <= (state_d == StDone);
        end
    end

    replay_dump_window #(
        .CYCLE_W(CYCLE_W)
    ) u_dump_window (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clr_i        (win_clr),
        .start_i      (win_start),
        .adv_i        (win_adv),
        .cnt_i        (cycles_inc),
        .dump_start_i (start_q),
        .dump_end_i   (end_q),
        .close_i      (win_close),
        .dump_on_o    (dump_on_o),
        .dump_off_o   (dump_off_o),
        .dump_active_o(dump_active_o)
    );

    assign cfg_ready_o  = cfg_ready_q;
    assign dut_reset_o  = dut_reset_q;
    assign tick_req_o   = tick_req_q;
    assign cycles_o     = cycles_q;
    assign finish_o     = finish_q;
    assign done_o       = done_q;
    assign exit_cause_o = cause_q;

endmodule

// File: tb/tb_replay_ctrl.sv
// Bench for replay_ctrl. A run-level model turns each configuration and ack
// pattern into the expected per-cycle output trace; a compare process checks
// every cycle of each run, and literal checks pin key values of every scenario.
module tb_replay_ctrl;

    localparam int CW   = 8;
    localparam int RW   = 16;
    localparam int CMAX = (1 << CW) - 1;
    localparam int NPAT = 512;
    localparam int NEXP = 1024;

    typedef struct packed {
        logic          rdy;
        logic          rs;
        logic          rq;
        logic [CW-1:0] cy;
        logic          on;
        logic          off;
        logic          act;
        logic          fin;
        logic          dn;
        logic [1:0]    cs;
    } obs_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_valid, cfg_ready;
    logic [RW-1:0] cfg_reset_len;
    logic [CW-1:0] cfg_dump_start, cfg_dump_end, cfg_max_cycles;
    logic          tick_req, tick_ack, tick_exit, dut_reset;
    logic [CW-1:0] cycles;
    logic          dump_on, dump_off, dump_active, finish, done;
    logic [1:0]    exit_cause;

    replay_ctrl #(
        .CYCLE_W(CW),
        .RST_W  (RW)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .cfg_valid_i     (cfg_valid),
        .cfg_ready_o     (cfg_ready),
        .cfg_reset_len_i (cfg_reset_len),
        .cfg_dump_start_i(cfg_dump_start),
        .cfg_dump_end_i  (cfg_dump_end),
        .cfg_max_cycles_i(cfg_max_cycles),
        .tick_req_o      (tick_req),
        .tick_ack_i      (tick_ack),
        .tick_exit_i     (tick_exit),
        .dut_reset_o     (dut_reset),
        .cycles_o        (cycles),
        .dump_on_o       (dump_on),
        .dump_off_o      (dump_off),
        .dump_active_o   (dump_active),
        .finish_o        (finish),
        .done_o          (done),
        .exit_cause_o    (exit_cause)
    );

    always #5 clk = ~clk;

    obs_t obs_now;
    assign obs_now = {cfg_ready, dut_reset, tick_req, cycles, dump_on, dump_off, dump_active,
                      finish, done, exit_cause};

    int   n_chk = 0;
    int   n_pass = 0;
    bit   ack_pat[NPAT];
    bit   exit_pat[NPAT];
    obs_t exp_tr[NEXP];
    int   n_exp;
    int   tcur;
    bit   chk_en = 1'b0;

    // Per-run observations gathered by the driver.
    int on_cnt, off_cnt, fin_cnt, first_low, on_cyc, off_cyc, on_t, off_t, fin_t;
    bit act_at_abort;

    function automatic obs_t mk(bit rdy, bit rs, bit rq, int cy, bit on, bit off, bit act,
                                bit fin, bit dn, int cs);
        mk = {rdy, rs, rq, CW'(cy), on, off, act, fin, dn, 2'(cs)};
    endfunction

    task automatic chk(input string name, input longint got, input longint want);
        n_chk++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, got, want);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            n_chk++;
            if (obs_now == exp_tr[tcur]) n_pass++;
            else $display("FAIL trace t=%0d: got %h, want %h", tcur, obs_now, exp_tr[tcur]);
        end
    end

    // Expected trace from the run rules: t=0 is the first cycle after the accept edge.
    task automatic build_model(input int l, input int st, input int en, input int mx);
        int t, k, cnt, cause, lp;
        bit opened, active, v_on, v_off, ended, pend;
        lp = (l == 0) ? 1 : l;
        t  = 0;
        for (int i = 0; i < lp; i++) begin
            exp_tr[t] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
            t++;
        end
        cnt    = 0;
        cause  = 0;
        v_on   = (st == 0);
        opened = v_on;
        active = v_on;
        v_off  = 0;
        ended  = 0;
        k      = 0;
        while (!ended && k < NPAT) begin
            exp_tr[t] = mk(0, 0, 1, cnt, v_on, v_off, active, 0, 0, 0);
            t++;
            v_on  = 0;
            v_off = 0;
            if (ack_pat[k]) begin
                if (exit_pat[k]) begin
                    cause = 1;
                    ended = 1;
                end else begin
                    if (cnt < CMAX) cnt++;
                    if (!opened && cnt == st) begin
                        v_on   = 1;
                        opened = 1;
                        active = 1;
                    end else if (active && en != 0 && en > st && cnt == en) begin
                        v_off  = 1;
                        active = 0;
                    end
                    if (mx != 0 && cnt == mx) begin
                        cause = 2;
                        ended = 1;
                    end
                end
            end
            k++;
        end
        if (ended) begin
            pend = active && v_on;
            if (active && !v_on) begin
                v_off  = 1;
                active = 0;
            end
            exp_tr[t] = mk(0, 0, 0, cnt, v_on, v_off, active, 0, 0, cause);
            t++;
            exp_tr[t] = mk(0, 0, 0, cnt, 0, pend, 0, 1, 0, cause);
            t++;
            for (int i = 0; i < 4; i++) begin
                exp_tr[t] = mk(0, 1, 0, cnt, 0, 0, 0, 0, 1, cause);
                t++;
            end
        end
        n_exp = t;
    endtask

    task automatic pat_cont(input int n_ack, input bit with_exit);
        for (int k = 0; k < NPAT; k++) begin
            ack_pat[k]  = (k < n_ack);
            exit_pat[k] = with_exit && (k == n_ack - 1);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_test(input string nm, input int l, input int st, input int en,
                            input int mx, input int abort_t);
        int r;
        build_model(l, st, en, mx);
        r         = (l == 0) ? 1 : l;
        on_cnt    = 0;
        off_cnt   = 0;
        fin_cnt   = 0;
        first_low = -1;
        on_cyc    = -1;
        off_cyc   = -1;
        on_t      = -1;
        off_t     = -1;
        fin_t     = -1;
        @(negedge clk);
        chk({nm, " cfg_ready"}, cfg_ready, 1);
        cfg_reset_len  = RW'(l);
        cfg_dump_start = CW'(st);
        cfg_dump_end   = CW'(en);
        cfg_max_cycles = CW'(mx);
        cfg_valid      = 1'b1;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        for (int t = 0; t < n_exp; t++) begin
            tcur = t;
            if (t >= r && (t - r) < NPAT) begin
                tick_ack  = ack_pat[t-r];
                tick_exit = exit_pat[t-r];
            end else begin
                tick_ack  = 1'b0;
                tick_exit = 1'b0;
            end
            chk_en = 1'b1;
            if (!dut_reset && first_low < 0) first_low = t;
            if (dump_on) begin
                on_cnt++;
                on_cyc = int'(cycles);
                on_t   = t;
            end
            if (dump_off) begin
                off_cnt++;
                off_cyc = int'(cycles);
                off_t   = t;
            end
            if (finish) begin
                fin_cnt++;
                fin_t = t;
            end
            if (t == abort_t) begin
                act_at_abort = dump_active;
                rst = 1'b1;
                @(posedge clk);
                #1;
                chk_en = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk_en    = 1'b0;
        tick_ack  = 1'b0;
        tick_exit = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        cfg_valid      = 1'b0;
        cfg_reset_len  = '0;
        cfg_dump_start = '0;
        cfg_dump_end   = '0;
        cfg_max_cycles = '0;
        tick_ack       = 1'b0;
        tick_exit      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset state", obs_now, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b0;

        // Ten acks then an exit; window opens on RUN entry.
        pat_cont(11, 1);
        run_test("t1", 3, 0, 0, 0, -1);
        chk("t1 model length", n_exp, 20);
        chk("t1 reset hold", first_low + 1, 4);
        chk("t1 dump_on time", on_t, 3);
        chk("t1 cycles", cycles, 10);
        chk("t1 exit_cause", exit_cause, 1);
        chk("t1 dump_off count", off_cnt, 1);
        chk("t1 finish after off", fin_t, off_t + 1);
        chk("t1 done", done, 1);
        do_reset();

        // Window 5..8 under a limit of 20.
        pat_cont(40, 0);
        run_test("t2", 0, 5, 8, 20, -1);
        chk("t2 reset hold", first_low + 1, 2);
        chk("t2 on at", on_cyc, 5);
        chk("t2 off at", off_cyc, 8);
        chk("t2 cycles", cycles, 20);
        chk("t2 exit_cause", exit_cause, 2);
        chk("t2 finish count", fin_cnt, 1);
        do_reset();

        // Exit on the ack that would reach the dump start.
        pat_cont(4, 1);
        run_test("t3", 2, 4, 0, 0, -1);
        chk("t3 dump_on count", on_cnt, 0);
        chk("t3 dump_off count", off_cnt, 0);
        chk("t3 cycles", cycles, 3);
        chk("t3 finish count", fin_cnt, 1);
        chk("t3 exit_cause", exit_cause, 1);
        do_reset();

        // Limit and dump start on the same ack.
        pat_cont(20, 0);
        run_test("t4", 1, 6, 0, 6, -1);
        chk("t4 on at", on_cyc, 6);
        chk("t4 off after on", off_t, on_t + 1);
        chk("t4 finish count", fin_cnt, 1);
        chk("t4 exit_cause", exit_cause, 2);
        do_reset();

        // Reset in the middle of a run with the window open.
        pat_cont(40, 1);
        run_test("t5", 1, 2, 0, 0, 5);
        chk("t5 active at abort", act_at_abort, 1);
        chk("t5 after reset", obs_now, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("t5 idle after reset", obs_now, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));

        // Gapped acks, limit 50; accepted straight after the aborted run.
        for (int k = 0; k < NPAT; k++) begin
            ack_pat[k]  = ($urandom_range(0, 2) != 0);
            exit_pat[k] = 1'b0;
        end
        run_test("t6", 5, 10, 30, 50, -1);
        chk("t6 cycles", cycles, 50);
        chk("t6 exit_cause", exit_cause, 2);
        chk("t6 on at", on_cyc, 10);
        chk("t6 off at", off_cyc, 30);
        repeat (20) @(posedge clk);
        #1;
        chk("t6 done sticky", done, 1);
        do_reset();
        chk("t6 done cleared", done, 0);

        // Saturation, with an end below the start so only CLOSE shuts the window.
        pat_cont(301, 1);
        run_test("t7", 1, 200, 100, 0, -1);
        chk("t7 cycles saturated", cycles, 255);
        chk("t7 on at", on_cyc, 200);
        chk("t7 dump_off count", off_cnt, 1);
        chk("t7 exit_cause", exit_cause, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
